// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller port bundle: hazard-detection inputs from ID/IE and the
// Stall/Flush/PC controls returned to the pipeline buffers and PC register.
interface pipeline_hazard_ctrl_if #(
   parameter int REG_W = 3
);
   logic [REG_W-1:0] id_rsrc;
   logic [REG_W-1:0] id_rdst;
   logic             id_uses_rsrc;
   logic             id_uses_rdst;
   logic             ie_mem_read;
   logic [REG_W-1:0] ie_rdst;
   logic             ie_branch_tkn;
   logic             ie_ret;

   logic             IF_Stall;
   logic             IF_Flush;
   logic             ID_Stall;
   logic             ID_Flush;
   logic             IE_Stall;
   logic             IE_Flush;
   logic             pc_write_en;
   logic [1:0]       pc_sel;

   modport master (
      output id_rsrc, id_rdst, id_uses_rsrc, id_uses_rdst,
      output ie_mem_read, ie_rdst, ie_branch_tkn, ie_ret,
      input  IF_Stall, IF_Flush, ID_Stall, ID_Flush, IE_Stall, IE_Flush,
      input  pc_write_en, pc_sel
   );

   modport slave (
      input  id_rsrc, id_rdst, id_uses_rsrc, id_uses_rdst,
      input  ie_mem_read, ie_rdst, ie_branch_tkn, ie_ret,
      output IF_Stall, IF_Flush, ID_Stall, ID_Flush, IE_Stall, IE_Flush,
      output pc_write_en, pc_sel
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, taken-branch flush, multi-cycle RET.
// Optional macro HAZARD_STATS_EN adds saturating stall_cnt / flush_cnt outputs.
module pipeline_hazard_ctrl #(
   parameter int REG_W      = 3,
   parameter int LU_CYCLES  = 1,
   parameter int RET_CYCLES = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   pipeline_hazard_ctrl_if.slave hz
`ifdef HAZARD_STATS_EN
   ,
   output logic [15:0]          stall_cnt,
   output logic [15:0]          flush_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_LU_WAIT  = 2'd1,
      ST_RET_WAIT = 2'd2
   } state_t;

   localparam logic [3:0] LU_LOAD  = (LU_CYCLES > 1) ? 4'(LU_CYCLES - 2) : 4'd0;
   localparam logic [3:0] RET_LOAD = 4'(RET_CYCLES - 2);

   state_t     state_r;
   state_t     state_s;
   logic [3:0] cnt_r;
   logic [3:0] cnt_s;

   logic       if_stall_s;
   logic       if_flush_s;
   logic       id_flush_s;
   logic       pc_we_s;
   logic [1:0] pc_sel_s;

   // ID consumer reads a register that the load in IE has not produced yet
   function automatic logic lu_match(
      input logic             mem_read,
      input logic [REG_W-1:0] ie_rd,
      input logic             uses_rsrc,
      input logic [REG_W-1:0] rsrc,
      input logic             uses_rdst,
      input logic [REG_W-1:0] rdst
   );
      return mem_read & ((uses_rsrc & (rsrc == ie_rd)) | (uses_rdst & (rdst == ie_rd)));
   endfunction

   // Next-state and Mealy control decode, RET > branch > load-use
   always_comb begin
      state_s    = state_r;
      cnt_s      = cnt_r;
      if_stall_s = 1'b0;
      if_flush_s = 1'b0;
      id_flush_s = 1'b0;
      pc_we_s    = 1'b1;
      pc_sel_s   = 2'd0;
      case (state_r)
         ST_RUN: begin
            if (hz.ie_ret) begin
               if_flush_s = 1'b1;
               id_flush_s = 1'b1;
               pc_we_s    = 1'b0;
               state_s    = ST_RET_WAIT;
               cnt_s      = RET_LOAD;
            end else if (hz.ie_branch_tkn) begin
               if_flush_s = 1'b1;
               id_flush_s = 1'b1;
               pc_sel_s   = 2'd1;
            end else if (lu_match(hz.ie_mem_read, hz.ie_rdst, hz.id_uses_rsrc,
                                  hz.id_rsrc, hz.id_uses_rdst, hz.id_rdst)) begin
               if_stall_s = 1'b1;
               id_flush_s = 1'b1;
               pc_we_s    = 1'b0;
               if (LU_CYCLES > 1) begin
                  state_s = ST_LU_WAIT;
                  cnt_s   = LU_LOAD;
               end else begin
                  state_s = ST_RUN;
               end
            end else begin
               state_s = ST_RUN;
            end
         end
         ST_LU_WAIT: begin
            if_stall_s = 1'b1;
            id_flush_s = 1'b1;
            pc_we_s    = 1'b0;
            if (cnt_r == 4'd0) begin
               state_s = ST_RUN;
            end else begin
               cnt_s = cnt_r - 4'd1;
            end
         end
         ST_RET_WAIT: begin
            if_flush_s = 1'b1;
            id_flush_s = 1'b1;
            // IE holds bubbles here, so branch/ret/load-use inputs are meaningless
            if (cnt_r == 4'd0) begin
               pc_we_s  = 1'b1;
               pc_sel_s = 2'd2;
               state_s  = ST_RUN;
            end else begin
               pc_we_s = 1'b0;
               cnt_s   = cnt_r - 4'd1;
            end
         end
         default: begin
            state_s = ST_RUN;
            cnt_s   = 4'd0;
         end
      endcase
   end

   // State and down-counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_RUN;
         cnt_r   <= 4'd0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
      end
   end

   // Controls drop to the reset pattern while rst_n is low, whatever the inputs
   always_comb begin
      if (!rst_n) begin
         hz.IF_Stall    = 1'b0;
         hz.IF_Flush    = 1'b0;
         hz.ID_Flush    = 1'b0;
         hz.pc_write_en = 1'b1;
         hz.pc_sel      = 2'd0;
      end else begin
         hz.IF_Stall    = if_stall_s;
         hz.IF_Flush    = if_flush_s;
         hz.ID_Flush    = id_flush_s;
         hz.pc_write_en = pc_we_s;
         hz.pc_sel      = pc_sel_s;
      end
   end

   assign hz.ID_Stall = 1'b0;
   assign hz.IE_Stall = 1'b0;
   assign hz.IE_Flush = 1'b0;

`ifdef HAZARD_STATS_EN
   logic [15:0] stall_cnt_r;
   logic [15:0] flush_cnt_r;

   // Saturating per-cycle stall / flush event counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_r <= 16'd0;
         flush_cnt_r <= 16'd0;
      end else begin
         if (if_stall_s && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'd1;
         end else begin
            stall_cnt_r <= stall_cnt_r;
         end
         if (if_flush_s && (flush_cnt_r != 16'hFFFF)) begin
            flush_cnt_r <= flush_cnt_r + 16'd1;
         end else begin
            flush_cnt_r <= flush_cnt_r;
         end
      end
   end

   assign stall_cnt = stall_cnt_r;
   assign flush_cnt = flush_cnt_r;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: two instances (LU_CYCLES 1 and 2)
// share the same stimulus; a negedge monitor pops expected controls for both.
module tb_pipeline_hazard_ctrl;

   // Control vector: {IF_Stall, IF_Flush, ID_Stall, ID_Flush, IE_Stall, IE_Flush, pc_write_en, pc_sel}
   localparam logic [8:0] NORM = 9'b0_0_0_0_0_0_1_00;
   localparam logic [8:0] LU   = 9'b1_0_0_1_0_0_0_00;
   localparam logic [8:0] BR   = 9'b0_1_0_1_0_0_1_01;
   localparam logic [8:0] RETF = 9'b0_1_0_1_0_0_0_00;
   localparam logic [8:0] RETL = 9'b0_1_0_1_0_0_1_10;

   typedef struct {
      string      name;
      logic [8:0] e1;
      logic [8:0] e2;
   } exp_t;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   exp_t sb_q[$];

   pipeline_hazard_ctrl_if #(.REG_W(3)) hz1 ();
   pipeline_hazard_ctrl_if #(.REG_W(3)) hz2 ();

`ifdef HAZARD_STATS_EN
   logic [15:0] sc1, fc1, sc2, fc2;
`endif

   pipeline_hazard_ctrl #(.REG_W(3), .LU_CYCLES(1), .RET_CYCLES(3)) dut1 (
      .clk(clk), .rst_n(rst_n), .hz(hz1)
`ifdef HAZARD_STATS_EN
      , .stall_cnt(sc1), .flush_cnt(fc1)
`endif
   );

   pipeline_hazard_ctrl #(.REG_W(3), .LU_CYCLES(2), .RET_CYCLES(3)) dut2 (
      .clk(clk), .rst_n(rst_n), .hz(hz2)
`ifdef HAZARD_STATS_EN
      , .stall_cnt(sc2), .flush_cnt(fc2)
`endif
   );

   logic [8:0] out1;
   logic [8:0] out2;
   assign out1 = {hz1.IF_Stall, hz1.IF_Flush, hz1.ID_Stall, hz1.ID_Flush,
                  hz1.IE_Stall, hz1.IE_Flush, hz1.pc_write_en, hz1.pc_sel};
   assign out2 = {hz2.IF_Stall, hz2.IF_Flush, hz2.ID_Stall, hz2.ID_Flush,
                  hz2.IE_Stall, hz2.IE_Flush, hz2.pc_write_en, hz2.pc_sel};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drv(input logic ret, input logic br, input logic mr, input logic [2:0] ierd,
                      input logic ursrc, input logic [2:0] rsrc,
                      input logic urdst, input logic [2:0] rdst);
      hz1.ie_ret = ret;          hz2.ie_ret = ret;
      hz1.ie_branch_tkn = br;    hz2.ie_branch_tkn = br;
      hz1.ie_mem_read = mr;      hz2.ie_mem_read = mr;
      hz1.ie_rdst = ierd;        hz2.ie_rdst = ierd;
      hz1.id_uses_rsrc = ursrc;  hz2.id_uses_rsrc = ursrc;
      hz1.id_rsrc = rsrc;        hz2.id_rsrc = rsrc;
      hz1.id_uses_rdst = urdst;  hz2.id_uses_rdst = urdst;
      hz1.id_rdst = rdst;        hz2.id_rdst = rdst;
   endtask

   // One clock of stimulus with the hand-computed controls for both instances
   task automatic cyc(input string name, input logic ret, input logic br, input logic mr,
                      input logic [2:0] ierd, input logic ursrc, input logic [2:0] rsrc,
                      input logic urdst, input logic [2:0] rdst,
                      input logic [8:0] e1, input logic [8:0] e2);
      exp_t e;
      @(posedge clk);
      #1;
      drv(ret, br, mr, ierd, ursrc, rsrc, urdst, rdst);
      e.name = name;
      e.e1   = e1;
      e.e2   = e2;
      sb_q.push_back(e);
   endtask

   task automatic idle(input string name, input logic [8:0] e1, input logic [8:0] e2);
      cyc(name, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, e1, e2);
   endtask

   // Monitor: compare DUT controls against the scoreboard mid-cycle
   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         check({e.name, "_lu1"}, {23'd0, out1}, {23'd0, e.e1});
         check({e.name, "_lu2"}, {23'd0, out2}, {23'd0, e.e2});
      end
   end

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      drv(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0);
      #2;
      check("reset_state_lu1", {23'd0, out1}, {23'd0, NORM});
      check("reset_state_lu2", {23'd0, out2}, {23'd0, NORM});
      #10 rst_n = 1'b1;

      idle("idle0", NORM, NORM);
      cyc("lu_rsrc",     1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 3'd3, 1'b0, 3'd0, LU, LU);
      idle("lu_rsrc_c2", NORM, LU);
      idle("lu_rsrc_c3", NORM, NORM);
      cyc("lu_rdst",     1'b0, 1'b0, 1'b1, 3'd5, 1'b0, 3'd5, 1'b1, 3'd5, LU, LU);
      cyc("lu_wait_br",  1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, BR, LU);
      cyc("no_match",    1'b0, 1'b0, 1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 3'd4, NORM, NORM);
      cyc("no_memread",  1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 3'd3, 1'b1, 3'd3, NORM, NORM);
      cyc("no_uses",     1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 3'd3, 1'b0, 3'd3, NORM, NORM);
      cyc("br_over_lu",  1'b0, 1'b1, 1'b1, 3'd3, 1'b1, 3'd3, 1'b0, 3'd0, BR, BR);
      cyc("ret_c1",      1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, RETF, RETF);
      cyc("ret_c2_br",   1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, RETF, RETF);
      cyc("ret_c3",      1'b1, 1'b0, 1'b1, 3'd3, 1'b1, 3'd3, 1'b0, 3'd0, RETL, RETL);
      idle("ret_after", NORM, NORM);
      cyc("ret_over_br", 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, RETF, RETF);
      idle("ret2_c2", RETF, RETF);
      idle("ret2_c3", RETL, RETL);
      idle("ret2_after", NORM, NORM);

      // Reset in the second RET cycle must clear controls before any clock edge
      cyc("rst_ret_c1",  1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, RETF, RETF);
      idle("rst_ret_c2", RETF, RETF);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      drv(1'b1, 1'b1, 1'b1, 3'd3, 1'b1, 3'd3, 1'b0, 3'd0);
      #1;
      check("rst_async_lu1", {23'd0, out1}, {23'd0, NORM});
      check("rst_async_lu2", {23'd0, out2}, {23'd0, NORM});
      @(posedge clk);
      #1;
      check("rst_hold_lu1", {23'd0, out1}, {23'd0, NORM});
      drv(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0);
      #2 rst_n = 1'b1;
      idle("post_rst_c1", NORM, NORM);
      idle("post_rst_c2", NORM, NORM);
      idle("post_rst_c3", NORM, NORM);

`ifdef HAZARD_STATS_EN
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("stats_clear_stall", {16'd0, sc1}, 32'd0);
      check("stats_clear_flush", {16'd0, fc1}, 32'd0);
      #3 rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         drv(1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 3'd3, 1'b0, 3'd0);
         repeat (2) begin
            @(posedge clk); #1;
            drv(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0);
         end
      end
      @(posedge clk); #1;
      drv(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0);
      repeat (3) begin
         @(posedge clk); #1;
         drv(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0);
      end
      drv(1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0);
      @(posedge clk); #1;
      drv(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0);
      @(posedge clk); #1;
      check("stats_stall_lu1", {16'd0, sc1}, 32'd5);
      check("stats_flush_lu1", {16'd0, fc1}, 32'd4);
      check("stats_stall_lu2", {16'd0, sc2}, 32'd10);
      drv(1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 3'd3, 1'b0, 3'd0);
      repeat (70000) @(posedge clk);
      #1;
      check("stats_sat_lu1", {16'd0, sc1}, 32'h0000FFFF);
      check("stats_sat_lu2", {16'd0, sc2}, 32'h0000FFFF);
      check("stats_flush_hold", {16'd0, fc1}, 32'd4);
      drv(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0);
`endif

      repeat (3) @(posedge clk);
      check("scoreboard_drained", sb_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
